fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the PC, instruction-memory and decode-side signals
// of the fetch stage into one bundle.
interface fetch_unit_if #(
  parameter int IW = 9,
  parameter int AW = 8
);
  logic [AW-1:0] pc_addr;
  logic          fetch_halt;
  logic          stop;
  logic          flush;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  // Environment side: PC, control, memory model and decode.
  modport master (
    output pc_addr, stop, flush, imem_rdata, out_ready,
    input  fetch_halt, imem_en, imem_addr, out_valid, out_instr, out_pc
  );

  // Fetch unit side.
  modport slave (
    input  pc_addr, stop, flush, imem_rdata, out_ready,
    output fetch_halt, imem_en, imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: issues the current PC to a 1-cycle synchronous instruction
// memory, tags each returned word with its PC and queues it in a small
// in-order buffer that feeds decode over valid/ready. The outstanding read
// counts towards occupancy, so the buffer can never overflow.
module fetch_unit #(
  parameter int IW    = 9,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  // Buffer storage; no reset needed, contents only matter while counted.
  logic [IW-1:0] instr_q [DEPTH];
  logic [AW-1:0] pc_q    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] tag_q, tag_d;

  logic [CW:0]   occupancy;
  logic          full_cond;
  logic          issue;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Occupancy includes the outstanding read so a returning word always has a slot.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign full_cond = (occupancy >= DEPTH_W);

  // Flush wins over halt so the PC can take the branch on the flush edge.
  assign issue          = !reset && !bus.flush && !bus.stop && !full_cond;
  assign bus.fetch_halt = !reset && !bus.flush && (bus.stop || full_cond);
  assign bus.imem_en    = issue;
  assign bus.imem_addr  = bus.pc_addr;

  // A response or pop coinciding with flush is discarded.
  assign push = inflight_q && !bus.flush;
  assign pop  = (count_q != '0) && bus.out_ready && !bus.flush;

  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_q[head_q];
  assign bus.out_pc    = pc_q[head_q];

  // Next-state for pointers, occupancy and the outstanding-read tag.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = issue;
    tag_d      = issue ? bus.pc_addr : tag_q;

    if (pop)  head_d = ptr_inc(head_q);
    if (push) tail_d = ptr_inc(tail_q);

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (bus.flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  // Write the returning word and its PC tag into the tail slot.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_q[tail_q] <= bus.imem_rdata;
      pc_q[tail_q]    <= tag_q;
    end
  end

endmodule
